alu_fu: RTL and testbench

Parametrised, pipelined integer ALU functional unit for the Tomasulo back end. It accepts one issued word per cycle from the ALU reservation station and computes the result over `STAGES` register stages. Results are held in an in-order output buffer and presented to the CDB arbiter with a request/grant handshake. It supersedes the purely combinational ALU: it adds back-pressure, credit-based issue, flush, and optional set-less-than support.

---
 rtl/alu_fu_if.sv | 31 +++
 rtl/alu_fu.sv | 118 +++++++++++
 tb/tb_alu_fu.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/alu_fu_if.sv
// alu_fu_if -- issue and CDB handshake bundle for the pipelined ALU unit.
//   in_*    : issued word from the ALU reservation station (valid/ready)
//   cdb_*   : buffer head offered to the CDB arbiter (req/gnt)
// master: RS + arbiter side. slave: the functional unit.
interface alu_fu_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic             in_arith;
  logic [2:0]       in_funct3;
  logic             in_funct7;
  logic [XLEN-1:0]  in_src1;
  logic [XLEN-1:0]  in_src2;
  logic [TAG_W-1:0] in_tag;
  logic             cdb_req;
  logic             cdb_gnt;
  logic [XLEN-1:0]  cdb_data;
  logic [TAG_W-1:0] cdb_tag;

  modport master (
    output in_valid, in_arith, in_funct3, in_funct7, in_src1, in_src2, in_tag, cdb_gnt,
    input  in_ready, cdb_req, cdb_data, cdb_tag
  );

  modport slave (
    input  in_valid, in_arith, in_funct3, in_funct7, in_src1, in_src2, in_tag, cdb_gnt,
    output in_ready, cdb_req, cdb_data, cdb_tag
  );
endinterface

// File: rtl/alu_fu.sv
// alu_fu -- pipelined integer ALU functional unit with in-order output buffer.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-low reset
//   flush : synchronous kill of every in-flight and buffered result
//   fu    : alu_fu_if.slave (issue valid/ready + CDB req/gnt)
// The result is formed combinationally at issue, carried through STAGES
// registers, then written into an OBUF_DEPTH-entry circular FIFO whose head
// drives the CDB. Issue is credit-gated so the pipeline never has to stall.
// Optional: define ALU_FU_SLT_EN to enable slt/sltu (funct3 010/011);
// otherwise those encodings produce 0.
module alu_fu #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 3,
  parameter int STAGES     = 2,
  parameter int OBUF_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     flush,
  alu_fu_if.slave  fu
);
  localparam int SH_W  = $clog2(XLEN);
  localparam int CR_W  = $clog2(OBUF_DEPTH + 1);
  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  data;
  } res_t;

  logic             issue, push, pop;
  logic [CR_W-1:0]  credits, count;
  logic [PTR_W-1:0] head, tail;
  logic [XLEN-1:0]  result;
  logic [SH_W-1:0]  shamt;
  logic [STAGES:1]  vld_pipe;
  res_t             res_pipe [1:STAGES];
  res_t             obuf [OBUF_DEPTH];

  // Credits count free slots across pipeline + buffer, so flush wins by
  // forcing ready low in its own cycle.
  assign fu.in_ready = (credits != '0) && !flush;
  assign issue       = fu.in_valid && fu.in_ready;
  assign push        = vld_pipe[STAGES];
  assign fu.cdb_req  = (count != '0);
  assign pop         = fu.cdb_req && fu.cdb_gnt && !flush;
  assign fu.cdb_data = obuf[head].data;
  assign fu.cdb_tag  = obuf[head].tag;
  assign shamt       = fu.in_src2[SH_W-1:0];

  always_comb begin
    result = fu.in_src1 + fu.in_src2;
    if (fu.in_arith) begin
      case (fu.in_funct3)
        3'b000: result = fu.in_funct7 ? fu.in_src1 - fu.in_src2 : fu.in_src1 + fu.in_src2;
        3'b001: result = fu.in_src1 << shamt;
        3'b101: result = fu.in_funct7 ? XLEN'($signed(fu.in_src1) >>> shamt)
                                      : fu.in_src1 >> shamt;
        3'b100: result = fu.in_src1 ^ fu.in_src2;
        3'b110: result = fu.in_src1 | fu.in_src2;
        3'b111: result = fu.in_src1 & fu.in_src2;
`ifdef ALU_FU_SLT_EN
        // funct3[0] picks the unsigned compare (sltu).
        default: result = {{(XLEN-1){1'b0}},
                           fu.in_funct3[0] ? (fu.in_src1 < fu.in_src2)
                                           : ($signed(fu.in_src1) < $signed(fu.in_src2))};
`else
        default: result = '0;
`endif
      endcase
    end
  end

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OBUF_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Stage 1 captures the computed result; later stages only shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      for (int i = 1; i <= STAGES; i++) res_pipe[i] <= '0;
    end else begin
      vld_pipe[1] <= issue;
      res_pipe[1] <= '{tag: fu.in_tag, data: result};
      for (int i = 2; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        res_pipe[i] <= res_pipe[i-1];
      end
      if (flush) vld_pipe <= '0;
    end
  end

  // Output FIFO and credit counter; flush restores the cold-start view.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      credits <= CR_W'(OBUF_DEPTH);
      for (int i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      credits <= CR_W'(OBUF_DEPTH);
    end else begin
      if (push) begin
        obuf[tail] <= res_pipe[STAGES];
        tail       <= ptr_inc(tail);
      end
      if (pop) head <= ptr_inc(head);
      count   <= count + CR_W'(push) - CR_W'(pop);
      credits <= credits - CR_W'(issue) + CR_W'(pop);
    end
  end
endmodule

// File: tb/tb_alu_fu.sv
// tb_alu_fu -- self-checking bench for alu_fu: directed vector table,
// multi-cycle corner sequences (back-pressure, flush, async reset) and
// randomized traffic against a queue-based reference model.
module tb_alu_fu;
  localparam int XLEN = 32, TAG_W = 3, STAGES = 2, DEPTH = 2;
`ifdef ALU_FU_SLT_EN
  localparam bit [31:0] SLT_E = 32'd1;
`else
  localparam bit [31:0] SLT_E = 32'd0;
`endif

  logic clk = 1'b0, rst = 1'b0, flush = 1'b0;
  always #5 clk = ~clk;

  alu_fu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();
  alu_fu #(.XLEN(XLEN), .TAG_W(TAG_W), .STAGES(STAGES), .OBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .fu(bus)
  );

  // Outstanding (issued, not yet popped) results in issue order; rdy is the
  // edge count after which the entry becomes visible at the buffer head.
  typedef struct { bit [31:0] data; bit [2:0] tag; int rdy; } exp_t;
  exp_t q[$];
  int edges = 0, checks = 0, passed = 0;
  always @(posedge clk) edges++;

  typedef struct {
    bit ar; bit [2:0] f3; bit f7; bit [31:0] a; bit [31:0] b; bit [2:0] tag; bit [31:0] expd;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h want %h (edge %0d)", name, act, req, edges);
  endtask

  // Reference ALU built from plain arithmetic (multiply/divide for shifts).
  function automatic bit [31:0] ref_alu(input bit ar, input bit [2:0] f3, input bit f7,
                                        input bit [31:0] a, input bit [31:0] b);
    longint unsigned ua = a, ub = b, pw = 1;
    longint sa = $signed(a), sb = $signed(b), sp;
    int sh = int'(b % 32);
    repeat (sh) pw = pw * 2;
    sp = longint'(pw);
    if (!ar) return 32'(ua + ub);
    case (f3)
      3'd0: return f7 ? 32'(ua - ub) : 32'(ua + ub);
      3'd1: return 32'(ua * pw);
      3'd5: if (!f7) return 32'(ua / pw);
            else return 32'((sa < 0) ? (sa - sp + 1) / sp : sa / sp);
      3'd4: return a ^ b;
      3'd6: return a | b;
      3'd7: return a & b;
      3'd2: return (sa < sb) ? SLT_E : 32'd0;
      default: return (ua < ub) ? SLT_E : 32'd0;
    endcase
  endfunction

  // One clock cycle: drive at negedge, check against the model, advance model.
  task automatic cycle(input bit v, input bit ar, input bit [2:0] f3, input bit f7,
                       input bit [31:0] a, input bit [31:0] b, input bit [2:0] tag,
                       input bit gnt, input bit fl, input bit [31:0] expd);
    bit ready_e, req_e;
    @(negedge clk);
    bus.in_valid = v; bus.in_arith = ar; bus.in_funct3 = f3; bus.in_funct7 = f7;
    bus.in_src1 = a; bus.in_src2 = b; bus.in_tag = tag; bus.cdb_gnt = gnt; flush = fl;
    #1;
    ready_e = (q.size() < DEPTH) && !fl;
    req_e   = (q.size() > 0) && (q[0].rdy <= edges);
    chk("in_ready", 32'(bus.in_ready), 32'(ready_e));
    chk("cdb_req", 32'(bus.cdb_req), 32'(req_e));
    if (req_e) begin
      chk("cdb_data", bus.cdb_data, q[0].data);
      chk("cdb_tag", 32'(bus.cdb_tag), 32'(q[0].tag));
    end
    if (fl) q.delete();
    else begin
      if (req_e && gnt) void'(q.pop_front());
      if (v && ready_e) q.push_back('{expd, tag, edges + 1 + STAGES});
    end
  endtask

  task automatic idle(input bit gnt, input int n);
    repeat (n) cycle(1'b0, 1'b0, 3'd0, 1'b0, 32'd0, 32'd0, 3'd0, gnt, 1'b0, 32'd0);
  endtask

  task automatic op(input bit ar, input bit [2:0] f3, input bit f7, input bit [31:0] a,
                    input bit [31:0] b, input bit [2:0] tag, input bit gnt);
    cycle(1'b1, ar, f3, f7, a, b, tag, gnt, 1'b0, ref_alu(ar, f3, f7, a, b));
  endtask

  task automatic hard_reset_check();
    #1;
    chk("rst_cdb_req", 32'(bus.cdb_req), 32'd0);
    chk("rst_cdb_data", bus.cdb_data, 32'd0);
    chk("rst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
  endtask

  initial begin
    tbl[0]  = '{1, 3'b000, 0, 32'd5,         32'd7,         3'd3, 32'd12};
    tbl[1]  = '{1, 3'b000, 1, 32'd3,         32'd5,         3'd1, 32'hFFFF_FFFE};
    tbl[2]  = '{1, 3'b101, 1, 32'h8000_0000, 32'd4,         3'd2, 32'hF800_0000};
    tbl[3]  = '{1, 3'b101, 0, 32'h8000_0000, 32'd4,         3'd4, 32'h0800_0000};
    tbl[4]  = '{1, 3'b001, 0, 32'd1,         32'd33,        3'd7, 32'd2};
    tbl[5]  = '{0, 3'b111, 0, 32'd6,         32'd3,         3'd0, 32'd9};
    tbl[6]  = '{1, 3'b100, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd1, 32'hF0F0_F0F0};
    tbl[7]  = '{1, 3'b110, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd2, 32'hFFF0_FFF0};
    tbl[8]  = '{1, 3'b111, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 3'd3, 32'h0F00_0F00};
    tbl[9]  = '{1, 3'b010, 0, 32'hFFFF_FFFF, 32'd1,         3'd5, SLT_E};
    tbl[10] = '{1, 3'b011, 0, 32'hFFFF_FFFF, 32'd1,         3'd6, 32'd0};
    tbl[11] = '{0, 3'b000, 1, 32'd10,        32'd3,         3'd4, 32'd13};
    tbl[12] = '{1, 3'b000, 1, 32'd0,         32'd1,         3'd5, 32'hFFFF_FFFF};
    tbl[13] = '{1, 3'b101, 1, 32'hFFFF_FFF0, 32'h24,        3'd6, 32'hFFFF_FFFF};

    bus.in_valid = 0; bus.in_arith = 0; bus.in_funct3 = 0; bus.in_funct7 = 0;
    bus.in_src1 = 0; bus.in_src2 = 0; bus.in_tag = 0; bus.cdb_gnt = 0;

    // Cold reset state, then release.
    hard_reset_check();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    idle(1'b1, 2);

    // Single add with grant held high.
    cycle(1'b1, 1'b1, 3'b000, 1'b0, 32'd5, 32'd7, 3'd3, 1'b1, 1'b0, 32'd12);
    idle(1'b1, 4);

    // Directed vectors, one per cycle, grant high.
    foreach (tbl[i])
      cycle(1'b1, tbl[i].ar, tbl[i].f3, tbl[i].f7, tbl[i].a, tbl[i].b, tbl[i].tag,
            1'b1, 1'b0, tbl[i].expd);
    idle(1'b1, STAGES + 3);

    // Back-pressure: fill credits with grant low, try one extra, then drain.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 3'b000, 1'b0, 32'(100 + i), 32'd1, 3'(i + 1), 1'b0);
    op(1'b1, 3'b000, 1'b0, 32'd999, 32'd1, 3'd7, 1'b0);
    idle(1'b0, STAGES + 1);
    idle(1'b1, DEPTH + 3);

    // Flush with one result buffered and one still in the pipeline.
    op(1'b1, 3'b110, 1'b0, 32'h11, 32'h22, 3'd2, 1'b0);
    op(1'b1, 3'b100, 1'b0, 32'h33, 32'h0F, 3'd3, 1'b0);
    idle(1'b0, STAGES - 1);
    cycle(1'b1, 1'b1, 3'b000, 1'b0, 32'd1, 32'd1, 3'd5, 1'b1, 1'b1, 32'd2);
    idle(1'b1, STAGES + 3);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      bit v = ($urandom_range(3) != 0);
      bit ar = ($urandom_range(7) != 0);
      bit [2:0] f3 = 3'($urandom_range(7));
      bit f7 = 1'($urandom_range(1));
      bit [31:0] a = $urandom(), b = ($urandom_range(3) == 0) ? 32'($urandom_range(40)) : $urandom();
      bit [2:0] tag = 3'($urandom_range(7));
      bit gnt = 1'($urandom_range(1));
      bit fl = ($urandom_range(31) == 0);
      cycle(v, ar, f3, f7, a, b, tag, gnt, fl, ref_alu(ar, f3, f7, a, b));
    end
    idle(1'b1, STAGES + DEPTH + 2);

    // Async reset mid-stream with the buffer full.
    for (int i = 0; i < DEPTH; i++) op(1'b1, 3'b001, 1'b0, 32'(3 + i), 32'd2, 3'(i + 4), 1'b0);
    idle(1'b0, STAGES + 1);
    @(posedge clk);
    #2 rst = 1'b0;
    hard_reset_check();
    bus.in_valid = 0; flush = 0;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Post-reset behaves as a cold start.
    idle(1'b1, 1);
    cycle(1'b1, 1'b1, 3'b000, 1'b0, 32'd5, 32'd7, 3'd3, 1'b1, 1'b0, 32'd12);
    idle(1'b1, 4);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
